// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate D-cache; read hits 0-wait, misses fill 4 words.
// Writes go through to memory and complete with m_ready; the CPU is stalled via c_ready=0.
module data_cache #(
    parameter int WORD_SIZE   = 16,
    parameter int INDEX_BITS  = 3,
    parameter int OFFSET_BITS = 2
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic                 c_readM,
    input  logic                 c_writeM,
    input  logic [WORD_SIZE-1:0] c_address,
    input  logic [WORD_SIZE-1:0] c_wdata,
    output logic [WORD_SIZE-1:0] c_rdata,
    output logic                 c_ready,
    output logic                 m_readM,
    output logic                 m_writeM,
    output logic [WORD_SIZE-1:0] m_address,
    output logic [WORD_SIZE-1:0] m_wdata,
    input  logic [WORD_SIZE-1:0] m_rdata,
    input  logic                 m_ready,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
);
    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS - OFFSET_BITS;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t state, state_nxt;

    logic [LINES-1:0]       valid;
    logic [TAG_BITS-1:0]    tags [LINES];
    logic [WORD_SIZE-1:0]   data [LINES][WORDS];
    logic [OFFSET_BITS-1:0] cnt;
    logic                   just_filled;

    logic [OFFSET_BITS-1:0] off;
    logic [INDEX_BITS-1:0]  idx;
    logic [TAG_BITS-1:0]    tag;
    logic                   hit;
    logic                   rd_req;

    assign off    = c_address[OFFSET_BITS-1:0];
    assign idx    = c_address[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    assign tag    = c_address[WORD_SIZE-1:OFFSET_BITS+INDEX_BITS];
    assign hit    = valid[idx] && (tags[idx] == tag);
    // A simultaneous read+write request is handled as a write.
    assign rd_req = c_readM && !c_writeM;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (c_writeM)           state_nxt = WRITE;
                else if (c_readM && !hit) state_nxt = FILL;
            end
            FILL:    if (m_ready && (&cnt)) state_nxt = IDLE;
            WRITE:   if (m_ready)           state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        c_ready   = 1'b0;
        c_rdata   = '0;
        m_readM   = 1'b0;
        m_writeM  = 1'b0;
        m_address = '0;
        m_wdata   = '0;
        unique case (state)
            IDLE: begin
                if (rd_req && hit) begin
                    c_ready = 1'b1;
                    c_rdata = data[idx][off];
                end
            end
            FILL: begin
                m_readM   = 1'b1;
                m_address = {tag, idx, cnt};
            end
            WRITE: begin
                m_writeM  = 1'b1;
                m_address = c_address;
                m_wdata   = c_wdata;
                c_ready   = m_ready;
            end
            default: ;
        endcase
    end

    // Control state and statistics.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            valid       <= '0;
            cnt         <= '0;
            just_filled <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            if (c_ready) just_filled <= 1'b0;
            if (state == IDLE && rd_req) begin
                if (hit) begin
                    if (!just_filled) hit_count <= hit_count + 16'd1;
                end else begin
                    cnt        <= '0;
                    miss_count <= miss_count + 16'd1;
                end
            end
            if (state == FILL && m_ready) begin
                cnt <= cnt + OFFSET_BITS'(1);
                if (&cnt) begin
                    valid[idx]  <= 1'b1;
                    just_filled <= 1'b1;
                end
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge Clk) begin
        if (state == FILL && m_ready) begin
            data[idx][cnt] <= m_rdata;
            if (&cnt) tags[idx] <= tag;
        end
        if (state == WRITE && m_ready && hit) begin
            data[idx][off] <= c_wdata;
        end
    end
endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the pipelined CPU data port and the slower data memory. Read hits return in the request cycle with no wait. Read misses stall the CPU through a `c_ready` handshake while a 4-word line is filled word by word. Writes always go through to memory; a write hit also updates the cached copy.

## Interface
Parameters:
- `WORD_SIZE`, 16, data/address width
- `INDEX_BITS`, 3, line index width (8 lines)
- `OFFSET_BITS`, 2, word offset width (4 words/line); tag = `WORD_SIZE-INDEX_BITS-OFFSET_BITS` = 11 bits

Ports:
- `Clk` in 1 — single clock, all state on rising edge
- `Reset_N` in 1 — asynchronous, active-low reset
- `c_readM` in 1 — CPU read request, held until `c_ready`
- `c_writeM` in 1 — CPU write request, held until `c_ready`
- `c_address` in 16 — CPU word address
- `c_wdata` in 16 — CPU write data
- `c_rdata` out 16 — read data, valid when `c_ready && c_readM`
- `c_ready` out 1 — request completes this cycle
- `m_readM` out 1 — memory word read request
- `m_writeM` out 1 — memory word write request
- `m_address` out 16 — memory word address
- `m_wdata` out 16 — memory write data
- `m_rdata` in 16 — memory read data, valid with `m_ready`
- `m_ready` in 1 — memory completes the current request this cycle; one-cycle pulse
- `hit_count` out 16 — completed reads whose first lookup hit; wraps
- `miss_count` out 16 — line fills started; wraps

## Operation
- Address split: offset = `[1:0]`, index = `[4:2]`, tag = `[15:5]`. Per line: valid bit, 11-bit tag, 4×16 data words.
- Hit condition: `valid[index] && tag[index]==c_address[15:5]`.
- FSM states are IDLE, FILL and WRITE. Reset state is IDLE.
- IDLE, read hit:
  - `c_ready=1` combinationally; `c_rdata` = cached word.
  - `hit_count++` unless the `just_filled` flag is set.
  - State stays IDLE.
- IDLE, read miss:
  - `c_ready=0`; go to FILL.
  - Fill counter is set to 0; `miss_count++`.
- FILL:
  - `m_readM=1`; `m_address={tag,index,cnt}`.
  - On `m_ready`: store `m_rdata` into word `cnt`, then `cnt++`.
  - After word 3: set valid and tag, set `just_filled`, return to IDLE.
  - The held read then hits on the next cycle.
- `just_filled` clears on any cycle with `c_ready=1`.
- IDLE, write (hit or miss): go to WRITE; `c_ready=0` in this cycle.
- WRITE:
  - `m_writeM=1`, `m_address=c_address`, `m_wdata=c_wdata`.
  - On `m_ready`: `c_ready=1`; if the line hits, update the cached word on the same edge; return to IDLE.
  - A write miss leaves the cache unchanged.
- `c_readM && c_writeM` together is illegal; the block treats it as a write.
- Outputs whenever their state is not active:
  - `m_readM`, `m_writeM` = 0; `m_address`, `m_wdata` = 0.
  - `c_rdata` = 0 when not a read hit in IDLE.
- An `m_ready` pulse arriving in IDLE is ignored.

## Timing
- Reset (asynchronous):
  - All valid bits = 0, state = IDLE, `cnt` = 0, `just_filled` = 0.
  - Counters = 0; all outputs = 0. Tag and data arrays need no reset.
- Reset mid-FILL or mid-WRITE:
  - The partially filled line stays invalid.
  - Memory requests drop immediately; no `c_ready` is issued.
- Read hit latency: 0 wait cycles (`c_ready` in the request cycle).
- Read miss latency: 1 (IDLE decision) + Σ(per-word memory latency) + 1 (hit cycle). With memory `m_ready` 2 cycles after the request is raised: 1 + 4×2 + 1 = 10 cycles.
- Write latency: 1 + memory latency; `c_ready` coincides with `m_ready`.
- Counter wrap: `0xFFFF` + 1 → `0x0000`.
- The CPU must hold address and data stable until `c_ready`. A new request may be presented on the cycle after `c_ready`.

## Test plan
- Reset, then read `0x0012`, with memory holding `mem[a]=a^0xA5A5` and 2-cycle latency:
  - Fill reads `0x0010`–`0x0013` in order.
  - `c_ready` arrives at cycle 10 with `c_rdata=0xA5B7`.
  - `miss_count=1`, `hit_count=0`.
- Read `0x0011`, then `0x0013`: each returns `c_ready` in the same cycle; `hit_count=2`, no memory activity.
- Write `0x0011`←`0x1234` (hit):
  - `m_writeM` is asserted with address `0x0011`.
  - A subsequent read of `0x0011` hits and returns `0x1234`.
- Write `0x0400`←`0xBEEF` (miss):
  - Memory is written.
  - A subsequent read of `0x0400` misses (`miss_count++`), fills, and returns `0xBEEF`.
- Conflict: read `0x0012`, then `0x0032` (same index 4, different tag), then `0x0012`: three fills, `miss_count=3`.
- Assert `Reset_N=0` after the second word of a fill, release, re-read the same address: a full 4-word fill occurs; the `valid` bit was not left set.
